conv_layer_controller: RTL and testbench
========================================

CONV_LAYER_CONTROLLER -- requirements
Module: conv_layer_controller

Interface
REQ-001 Parameter OUT_ROWS, default 6: output rows per frame; equals IMAGE_SIZE-KERNEL_SIZE+1.
REQ-002 Parameter TIMEOUT, default 64: max cycles spent in any wait state before error.
REQ-003 Parameter BIAS_IDX, default 9: weight_idx value that selects the bias term (KERNEL_SIZE*KERNEL_SIZE).
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to process one frame; honoured only in IDLE or ERROR.
REQ-007 ack  input  2  input-interface acknowledge: 0 idle, 1 preload fin, 2 shift fin, 3 load fin.
REQ-008 cmd  output  2  input-interface command: 0 idle, 1 preload, 2 shift, 3 load.
REQ-009 if_enable  output  1  input-interface enable.
REQ-010 weight_idx  output  4  kernel weight-select index for the current shift cycle.
REQ-011 acc_clear  output  1  one-cycle pulse that clears the kernel accumulators.
REQ-012 row_done  output  1  one-cycle pulse: kernel outputs for row_idx are final.
REQ-013 row_idx  output  3  output row currently being computed, 0..OUT_ROWS-1.
REQ-014 busy  output  1  high in every state except IDLE and ERROR.
REQ-015 done  output  1  one-cycle pulse at frame completion.
REQ-016 err  output  1  sticky timeout flag.
REQ-017 state  output  3  FSM state encoding, for debug: IDLE 0, PRELOAD_WAIT 1, SHIFT_WAIT 2, LOAD_WAIT 3, DONE 4, ERROR 5.

Function
REQ-018 All outputs SHALL be registered, except if_enable.
- if_enable is combinational: if_enable = !err.
REQ-019 cmd SHALL be nonzero for exactly one cycle per issue; otherwise 0.
REQ-020 IDLE: on start=1, issue cmd=1, row_idx:=0, go PRELOAD_WAIT.
REQ-021 PRELOAD_WAIT: on ack=1, issue cmd=2, pulse acc_clear, weight_idx:=0, go SHIFT_WAIT.
REQ-022 SHIFT_WAIT behaviour:
- weight_idx increments by 1 each cycle and saturates at BIAS_IDX.
- On ack=2: pulse row_done.
- If row_idx=OUT_ROWS-1, go DONE.
- Otherwise issue cmd=3 and go LOAD_WAIT.
REQ-023 LOAD_WAIT: on ack=3, row_idx:=row_idx+1, issue cmd=2, pulse acc_clear, weight_idx:=0, go SHIFT_WAIT.
REQ-024 DONE: pulse done for one cycle, then go IDLE; weight_idx:=0.
REQ-025 Ack handling:
- An ack code that does not match the current wait state is ignored.
- ack is ignored entirely in IDLE, DONE and ERROR.
REQ-026 Wait counter:
- Clears on entry to each wait state and increments each cycle while waiting.
- If it reaches TIMEOUT-1 with no matching ack: go ERROR, set err=1, cmd=0.
REQ-027 A matching ack in the same cycle as the timeout SHALL take priority; no error is raised.
REQ-028 ERROR: outputs hold, err=1, if_enable=0; start clears err and goes IDLE; cmd is not issued that cycle.
REQ-029 start while busy SHALL be ignored and SHALL NOT alter the counters.
REQ-030 row_idx SHALL never exceed OUT_ROWS-1; there is no wrap within a frame.

Reset
REQ-031 On rst_n=0, at any time including mid-frame, state:=IDLE and the wait counter is cleared.
REQ-032 Reset values: cmd=0, weight_idx=0, acc_clear=0, row_done=0, row_idx=0, busy=0, done=0, err=0.
REQ-033 After rst_n deasserts, the first start SHALL be honoured on the next rising edge.

Verification
REQ-034 Full frame: start, ack=1 after 30 cycles, each shift ack=2 10 cycles after cmd=2, each load ack=3 8 cycles after cmd=3.
- Required: cmd sequence 1,2,(3,2)x5.
- Required: 6 row_done pulses with row_idx 0..5.
- Required: one done pulse, then busy=0.
REQ-035 weight_idx profile: no ack=2 for 12 cycles after cmd=2.
- Required: weight_idx 0,1,...,9,9,9.
- Required: returns to 0 with the acc_clear pulse of the next shift.
REQ-036 Timeout: TIMEOUT=64, no ack after cmd=1.
- Required: ERROR at wait cycle 63, err=1, if_enable=0, cmd=0.
- Then start: err=0, state=IDLE.
REQ-037 Race: ack=3 arrives exactly on wait cycle 63.
- Required: no error; row_idx increments; cmd=2.
REQ-038 Robustness: start pulsed during SHIFT_WAIT, and ack=3 injected during SHIFT_WAIT.
- Required: both ignored; sequence unchanged.
REQ-039 Reset mid-frame: rst_n=0 in LOAD_WAIT at row_idx=3.
- Required: all outputs at reset values immediately (asynchronous).
- A new start then begins at row_idx=0 with cmd=1.

Source files
------------

// File: rtl/conv_layer_controller.sv
// rtl/conv_layer_controller.sv - row sequencer for a sliding-window convolution layer
// Drives preload/shift/load commands to the input interface and times kernel accumulation per output row.
module conv_layer_controller #(
   parameter int OUT_ROWS = 6,
   parameter int TIMEOUT  = 64,
   parameter int BIAS_IDX = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] ack,
   output logic [1:0] cmd,
   output logic       if_enable,
   output logic [3:0] weight_idx,
   output logic       acc_clear,
   output logic       row_done,
   output logic [2:0] row_idx,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE         = 3'd0,
      S_PRELOAD_WAIT = 3'd1,
      S_SHIFT_WAIT   = 3'd2,
      S_LOAD_WAIT    = 3'd3,
      S_DONE         = 3'd4,
      S_ERROR        = 3'd5
   } state_t;

   localparam int             CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT - 1);
   localparam logic [3:0]     BIAS     = 4'(BIAS_IDX);
   localparam logic [2:0]     LAST_ROW = 3'(OUT_ROWS - 1);

   localparam logic [1:0] CMD_IDLE    = 2'd0;
   localparam logic [1:0] CMD_PRELOAD = 2'd1;
   localparam logic [1:0] CMD_SHIFT   = 2'd2;
   localparam logic [1:0] CMD_LOAD    = 2'd3;

   state_t         state_q, state_n;
   logic [CW-1:0]  cnt_q, cnt_n;
   logic [1:0]     cmd_n;
   logic [3:0]     weight_n;
   logic [2:0]     row_n;
   logic           acc_clear_n, row_done_n, done_n, err_n, busy_n;
   logic           wait_expired;

   assign wait_expired = (cnt_q == CNT_MAX);
   assign if_enable    = !err;
   assign state        = state_q;

   always_comb begin
      state_n     = state_q;
      cnt_n       = cnt_q;
      cmd_n       = CMD_IDLE;
      weight_n    = weight_idx;
      row_n       = row_idx;
      acc_clear_n = 1'b0;
      row_done_n  = 1'b0;
      done_n      = 1'b0;
      err_n       = err;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               cmd_n   = CMD_PRELOAD;
               row_n   = 3'd0;
               cnt_n   = '0;
               state_n = S_PRELOAD_WAIT;
            end
         end
         S_PRELOAD_WAIT: begin
            if (ack == 2'd1) begin
               cmd_n       = CMD_SHIFT;
               acc_clear_n = 1'b1;
               weight_n    = 4'd0;
               cnt_n       = '0;
               state_n     = S_SHIFT_WAIT;
            end else if (wait_expired) begin
               err_n   = 1'b1;
               state_n = S_ERROR;
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end
         S_SHIFT_WAIT: begin
            // Walk the kernel taps, then park on the bias term until the shift finishes
            weight_n = (weight_idx >= BIAS) ? BIAS : weight_idx + 4'd1;
            if (ack == 2'd2) begin
               row_done_n = 1'b1;
               cnt_n      = '0;
               if (row_idx == LAST_ROW) begin
                  done_n  = 1'b1;
                  state_n = S_DONE;
               end else begin
                  cmd_n   = CMD_LOAD;
                  state_n = S_LOAD_WAIT;
               end
            end else if (wait_expired) begin
               err_n   = 1'b1;
               state_n = S_ERROR;
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end
         S_LOAD_WAIT: begin
            if (ack == 2'd3) begin
               row_n       = (row_idx < LAST_ROW) ? row_idx + 3'd1 : LAST_ROW;
               cmd_n       = CMD_SHIFT;
               acc_clear_n = 1'b1;
               weight_n    = 4'd0;
               cnt_n       = '0;
               state_n     = S_SHIFT_WAIT;
            end else if (wait_expired) begin
               err_n   = 1'b1;
               state_n = S_ERROR;
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            weight_n = 4'd0;
            state_n  = S_IDLE;
         end
         S_ERROR: begin
            if (start) begin
               err_n   = 1'b0;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase

      busy_n = (state_n != S_IDLE) && (state_n != S_ERROR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         cmd        <= CMD_IDLE;
         weight_idx <= 4'd0;
         acc_clear  <= 1'b0;
         row_done   <= 1'b0;
         row_idx    <= 3'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         cmd        <= cmd_n;
         weight_idx <= weight_n;
         acc_clear  <= acc_clear_n;
         row_done   <= row_done_n;
         row_idx    <= row_n;
         busy       <= busy_n;
         done       <= done_n;
         err        <= err_n;
      end
   end

endmodule

// File: tb/tb_conv_layer_controller.sv
// tb/tb_conv_layer_controller.sv - directed checks for conv_layer_controller
module tb_conv_layer_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] ack = 2'd0;
   logic [1:0] cmd;
   logic       if_enable;
   logic [3:0] weight_idx;
   logic       acc_clear;
   logic       row_done;
   logic [2:0] row_idx;
   logic       busy;
   logic       done;
   logic       err;
   logic [2:0] state;

   int tests_run = 0;
   int tests_failed = 0;

   conv_layer_controller #(.OUT_ROWS(6), .TIMEOUT(64), .BIAS_IDX(9)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ack(ack), .cmd(cmd),
      .if_enable(if_enable), .weight_idx(weight_idx), .acc_clear(acc_clear),
      .row_done(row_done), .row_idx(row_idx), .busy(busy), .done(done),
      .err(err), .state(state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      start = 1'b0;
      ack   = 2'd0;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Ends on the first negedge inside SHIFT_WAIT for row 0
   task automatic go_shift();
      start = 1'b1;
      tick();
      start = 1'b0;
      ack = 2'd1;
      tick();
      ack = 2'd0;
   endtask

   task automatic test_reset();
      start = 1'b0;
      ack   = 2'd0;
      rst_n = 1'b0;
      tick();
      tests_run++;
      if ({cmd, weight_idx, acc_clear, row_done, row_idx, busy, done, err, state} !== 19'd0) begin
         tests_failed++;
         $display("FAIL reset_vals got cmd=%0d w=%0d clr=%0d rd=%0d row=%0d busy=%0d done=%0d err=%0d st=%0d want all 0",
                  cmd, weight_idx, acc_clear, row_done, row_idx, busy, done, err, state);
      end
      tests_run++;
      if (if_enable !== 1'b1) begin tests_failed++; $display("FAIL reset_if_enable got %0d want 1", if_enable); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_full_frame();
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      tests_run++;
      if (cmd !== 2'd1 || state !== 3'd1 || busy !== 1'b1) begin
         tests_failed++; $display("FAIL ff_preload got cmd=%0d st=%0d busy=%0d want 1 1 1", cmd, state, busy);
      end
      repeat (30) tick();
      ack = 2'd1;
      tick();
      ack = 2'd0;
      tests_run++;
      if (cmd !== 2'd2 || acc_clear !== 1'b1 || weight_idx !== 4'd0 || state !== 3'd2) begin
         tests_failed++; $display("FAIL ff_first_shift got cmd=%0d clr=%0d w=%0d st=%0d want 2 1 0 2", cmd, acc_clear, weight_idx, state);
      end
      for (int r = 0; r < 6; r++) begin
         repeat (10) tick();
         ack = 2'd2;
         tick();
         ack = 2'd0;
         tests_run++;
         if (row_done !== 1'b1 || row_idx !== 3'(r)) begin
            tests_failed++; $display("FAIL ff_row_done r=%0d got rd=%0d row=%0d want 1 %0d", r, row_done, row_idx, r);
         end
         if (r < 5) begin
            tests_run++;
            if (cmd !== 2'd3 || state !== 3'd3 || done !== 1'b0) begin
               tests_failed++; $display("FAIL ff_load r=%0d got cmd=%0d st=%0d done=%0d want 3 3 0", r, cmd, state, done);
            end
            repeat (8) tick();
            ack = 2'd3;
            tick();
            ack = 2'd0;
            tests_run++;
            if (cmd !== 2'd2 || acc_clear !== 1'b1 || row_idx !== 3'(r + 1)) begin
               tests_failed++; $display("FAIL ff_next_shift r=%0d got cmd=%0d clr=%0d row=%0d want 2 1 %0d", r, cmd, acc_clear, row_idx, r + 1);
            end
         end else begin
            tests_run++;
            if (cmd !== 2'd0 || state !== 3'd4 || done !== 1'b1) begin
               tests_failed++; $display("FAIL ff_done got cmd=%0d st=%0d done=%0d want 0 4 1", cmd, state, done);
            end
            tick();
            tests_run++;
            if (busy !== 1'b0 || done !== 1'b0 || state !== 3'd0 || weight_idx !== 4'd0) begin
               tests_failed++; $display("FAIL ff_idle got busy=%0d done=%0d st=%0d w=%0d want 0 0 0 0", busy, done, state, weight_idx);
            end
         end
      end
   endtask

   task automatic test_weight_profile();
      do_reset();
      go_shift();
      for (int k = 0; k < 12; k++) begin
         tests_run++;
         if (weight_idx !== 4'((k < 9) ? k : 9)) begin
            tests_failed++; $display("FAIL wp_step k=%0d got %0d want %0d", k, weight_idx, (k < 9) ? k : 9);
         end
         if (k == 1) begin
            tests_run++;
            if (cmd !== 2'd0) begin tests_failed++; $display("FAIL wp_cmd_one_cycle got %0d want 0", cmd); end
         end
         if (k < 11) tick();
      end
      ack = 2'd2;
      tick();
      ack = 2'd3;
      tests_run++;
      if (cmd !== 2'd3 || weight_idx !== 4'd9) begin
         tests_failed++; $display("FAIL wp_load got cmd=%0d w=%0d want 3 9", cmd, weight_idx);
      end
      tick();
      ack = 2'd0;
      tests_run++;
      if (weight_idx !== 4'd0 || acc_clear !== 1'b1) begin
         tests_failed++; $display("FAIL wp_clear got w=%0d clr=%0d want 0 1", weight_idx, acc_clear);
      end
      tick();
      tests_run++;
      if (weight_idx !== 4'd1 || acc_clear !== 1'b0 || cmd !== 2'd0) begin
         tests_failed++; $display("FAIL wp_restart got w=%0d clr=%0d cmd=%0d want 1 0 0", weight_idx, acc_clear, cmd);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (63) tick();
      tests_run++;
      if (state !== 3'd1 || err !== 1'b0) begin
         tests_failed++; $display("FAIL to_before got st=%0d err=%0d want 1 0", state, err);
      end
      tick();
      tests_run++;
      if (state !== 3'd5 || err !== 1'b1 || if_enable !== 1'b0 || cmd !== 2'd0 || busy !== 1'b0) begin
         tests_failed++; $display("FAIL to_error got st=%0d err=%0d en=%0d cmd=%0d busy=%0d want 5 1 0 0 0", state, err, if_enable, cmd, busy);
      end
      ack = 2'd1;
      tick();
      ack = 2'd0;
      tests_run++;
      if (state !== 3'd5 || cmd !== 2'd0) begin
         tests_failed++; $display("FAIL to_ack_ignored got st=%0d cmd=%0d want 5 0", state, cmd);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tests_run++;
      if (state !== 3'd0 || err !== 1'b0 || if_enable !== 1'b1 || cmd !== 2'd0) begin
         tests_failed++; $display("FAIL to_recover got st=%0d err=%0d en=%0d cmd=%0d want 0 0 1 0", state, err, if_enable, cmd);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tests_run++;
      if (cmd !== 2'd1 || state !== 3'd1) begin
         tests_failed++; $display("FAIL to_restart got cmd=%0d st=%0d want 1 1", cmd, state);
      end
   endtask

   task automatic test_race();
      do_reset();
      go_shift();
      ack = 2'd2;
      tick();
      ack = 2'd0;
      tests_run++;
      if (cmd !== 2'd3 || state !== 3'd3) begin
         tests_failed++; $display("FAIL race_load got cmd=%0d st=%0d want 3 3", cmd, state);
      end
      repeat (63) tick();
      ack = 2'd3;
      tick();
      ack = 2'd0;
      tests_run++;
      if (state !== 3'd2 || err !== 1'b0 || row_idx !== 3'd1 || cmd !== 2'd2) begin
         tests_failed++; $display("FAIL race_ack_wins got st=%0d err=%0d row=%0d cmd=%0d want 2 0 1 2", state, err, row_idx, cmd);
      end
   endtask

   task automatic test_robustness();
      do_reset();
      go_shift();
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      ack = 2'd3;
      tick();
      ack = 2'd0;
      tests_run++;
      if (state !== 3'd2 || cmd !== 2'd0 || weight_idx !== 4'd4 || row_idx !== 3'd0 || busy !== 1'b1) begin
         tests_failed++; $display("FAIL rb_ignored got st=%0d cmd=%0d w=%0d row=%0d busy=%0d want 2 0 4 0 1", state, cmd, weight_idx, row_idx, busy);
      end
      ack = 2'd2;
      tick();
      ack = 2'd3;
      tests_run++;
      if (cmd !== 2'd3 || row_done !== 1'b1 || row_idx !== 3'd0) begin
         tests_failed++; $display("FAIL rb_shift_fin got cmd=%0d rd=%0d row=%0d want 3 1 0", cmd, row_done, row_idx);
      end
      tick();
      ack = 2'd0;
      tests_run++;
      if (cmd !== 2'd2 || row_idx !== 3'd1) begin
         tests_failed++; $display("FAIL rb_next_row got cmd=%0d row=%0d want 2 1", cmd, row_idx);
      end
   endtask

   task automatic test_reset_midframe();
      do_reset();
      go_shift();
      for (int r = 0; r < 3; r++) begin
         ack = 2'd2;
         tick();
         ack = 2'd3;
         tick();
         ack = 2'd0;
      end
      ack = 2'd2;
      tick();
      ack = 2'd0;
      tests_run++;
      if (state !== 3'd3 || row_idx !== 3'd3 || row_done !== 1'b1) begin
         tests_failed++; $display("FAIL mr_setup got st=%0d row=%0d rd=%0d want 3 3 1", state, row_idx, row_done);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({cmd, weight_idx, acc_clear, row_done, row_idx, busy, done, err, state} !== 19'd0) begin
         tests_failed++;
         $display("FAIL mr_async got cmd=%0d w=%0d clr=%0d rd=%0d row=%0d busy=%0d done=%0d err=%0d st=%0d want all 0",
                  cmd, weight_idx, acc_clear, row_done, row_idx, busy, done, err, state);
      end
      tick();
      rst_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tests_run++;
      if (cmd !== 2'd1 || row_idx !== 3'd0 || state !== 3'd1) begin
         tests_failed++; $display("FAIL mr_restart got cmd=%0d row=%0d st=%0d want 1 0 1", cmd, row_idx, state);
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_full_frame();
      test_weight_profile();
      test_timeout();
      test_race();
      test_robustness();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
